sign_narrow: RTL and testbench
==============================

# sign_narrow

Streaming 32-to-16-bit signed narrowing unit: the inverse of 16-to-32 sign extension on the store/writeback side of the CPU datapath. It accepts 32-bit signed words over a valid/ready handshake and checks whether each value is representable in 16 bits, meaning it would sign-extend back to the same word. It emits a wrapped or saturated 16-bit result plus an overflow flag through a 2-entry output buffer, and keeps a sticky saturating overflow counter for debug.

## Interface
- No parameters; widths fixed at 32 in / 16 out, 2-entry buffer, 8-bit counter.
- clk  input  1  rising-edge clock; single clock domain.
- reset_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  input  1  Din/sat_mode valid this cycle.
- in_ready  output  1  unit can accept; transfer when in_valid & in_ready at rising edge.
- Din  input  32  signed source word.
- sat_mode  input  1  1 = saturate on overflow, 0 = wrap (truncate); sampled per word at accept.
- out_valid  output  1  Dout/ovf hold a result.
- out_ready  input  1  consumer accepts; pop when out_valid & out_ready at rising edge.
- Dout  output  16  narrowed result at buffer head.
- ovf  output  1  head result was not representable in 16 bits.
- ovf_cnt  output  8  count of accepted overflowing words, saturates at 255.
- ovf_clr  input  1  synchronous clear of ovf_cnt.

## Operation
- Representable iff Din[31:15] are all equal (all 0 or all 1).
- Per accepted word, computed at accept and stored in the buffer entry:
  - Wrap mode: result = Din[15:0].
  - Saturate mode: result = 16'h7FFF if overflow and Din[31]=0; 16'h8000 if overflow and Din[31]=1; else Din[15:0].
  - ovf = ~representable, independent of mode.
- Buffer: 2-entry FIFO of {result, ovf}; head drives Dout/ovf; write/read pointers wrap mod 2; occupancy 0..2.
- in_ready = (occupancy < 2), driven from registered state only. No combinational path from out_ready or in_valid.
- out_valid = (occupancy > 0).
- Push and pop in the same cycle at occupancy 1: occupancy stays 1, and the new word becomes head on the next cycle. At occupancy 2 no push is possible; a pop reduces occupancy to 1.
- Pop with occupancy 0 cannot occur because out_valid is 0; push with occupancy 2 cannot occur because in_ready is 0.
- ovf_cnt increments by 1 on each accepted word with ovf=1, holds at 255.
  - ovf_clr applies first: clear and overflowing accept in the same cycle gives ovf_cnt = 1.
  - Clear alone gives ovf_cnt = 0.
- Dout holds its value while out_valid=1 and out_ready=0 (stall); no result is dropped or duplicated.

## Timing
- Reset (reset_n=0 at an edge): occupancy 0, pointers 0, out_valid 0, Dout 16'h0000, ovf 0, ovf_cnt 0, in_ready 0 while reset_n is low. In-flight entries are discarded.
- in_ready becomes 1 in the first cycle after the edge where reset_n is sampled high.
- Latency: a word accepted at edge k appears on Dout with out_valid=1 in the cycle after edge k (1 cycle).
- Throughput: 1 word/cycle sustained while out_ready=1.
- Backpressure: with out_ready=0, two words are absorbed, then in_ready drops in the cycle after the second accept. It reasserts in the cycle after the first pop.
- Outputs Dout, ovf, out_valid, in_ready and ovf_cnt all change only on rising edges of clk.

## Test plan
- Reset then sat_mode=0, Din=32'h00001234 -> next cycle out_valid=1, Dout=16'h1234, ovf=0; ovf_cnt=0.
- Representability boundaries:
  - Din=32'hFFFF8000 -> Dout=16'h8000, ovf=0.
  - Din=32'h00007FFF -> 16'h7FFF, ovf=0.
  - Din=32'h00008000, sat_mode=1 -> 16'h7FFF, ovf=1.
  - Same Din, sat_mode=0 -> 16'h8000, ovf=1.
  - Din=32'h80000000, sat_mode=1 -> 16'h8000, ovf=1.
- Backpressure: out_ready=0, push 3 consecutive words -> first two accepted, in_ready=0 thereafter. Raise out_ready -> results emerge in order, no loss or duplication, in_ready returns 1 the cycle after the first pop.
- Full throughput: 10 back-to-back words with out_ready=1 -> 10 results on 10 consecutive cycles starting 1 cycle after the first accept, occupancy stays 1.
- Counter: 257 overflowing words -> ovf_cnt holds 255. Assert ovf_clr together with one overflowing accept -> ovf_cnt=1. ovf_clr alone -> 0.
- Reset mid-operation: buffer full, assert reset_n=0 for one edge -> out_valid=0, Dout=0, ovf_cnt=0, in_ready=0, then in_ready=1 the cycle after reset deasserts. No stale data emerges.

Source files
------------

// File: rtl/sign_narrow.sv
// sign_narrow: 32-to-16-bit signed narrowing with wrap/saturate, overflow flag,
// 2-entry output buffer and a sticky saturating overflow counter.
module sign_narrow (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] Din,
   input  logic        sat_mode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] Dout,
   output logic        ovf,
   output logic [7:0]  ovf_cnt,
   input  logic        ovf_clr
);
   logic [1:0][16:0] mem_q, mem_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       occ_q, occ_d;
   logic             live_q, live_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             repr, push, pop, bump;
   logic [15:0]      res;
   // live_q keeps in_ready low for the cycle after a reset edge
   assign in_ready  = live_q & (occ_q != 2'd2);
   assign out_valid = occ_q != 2'd0;
   assign {Dout, ovf} = mem_q[rd_ptr_q];
   assign ovf_cnt   = cnt_q;
   always_comb begin
      repr     = (&Din[31:15]) | ~(|Din[31:15]);
      res      = (sat_mode & ~repr) ? (Din[31] ? 16'h8000 : 16'h7fff) : Din[15:0];
      push     = in_valid & in_ready;
      pop      = out_valid & out_ready;
      bump     = push & ~repr;
      mem_d    = mem_q;
      if (push) mem_d[wr_ptr_q] = {res, ~repr};
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
      live_d   = 1'b1;
      cnt_d    = ovf_clr ? {7'd0, bump} : cnt_q + {7'd0, bump & (cnt_q != 8'hff)};
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mem_q    <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
         live_q   <= 1'b0;
         cnt_q    <= 8'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         live_q   <= live_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

// File: tb/tb_sign_narrow.sv
// tb_sign_narrow: table-driven vectors plus scoreboard-checked stream sequences.
module tb_sign_narrow;
   logic        clk = 1'b0;
   logic        reset_n, in_valid, in_ready, sat_mode, out_valid, out_ready, ovf, ovf_clr;
   logic [31:0] din;
   logic [15:0] dout;
   logic [7:0]  ovf_cnt;
   int          checks = 0, errors = 0;
   logic [16:0] sb[$];
   typedef struct {
      logic [31:0] d;
      logic        s;
      logic [15:0] ed;
      logic        eo;
   } vec_t;
   vec_t tbl[10];

   sign_narrow dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .Din(din), .sat_mode(sat_mode), .out_valid(out_valid), .out_ready(out_ready),
      .Dout(dout), .ovf(ovf), .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Pops happen at the next rising edge when out_valid & out_ready are seen here
   always @(negedge clk) begin
      if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) chk("sb_unexpected_out", {15'd0, dout, ovf}, 32'h1ffff);
         else chk("sb_result", {15'd0, dout, ovf}, {15'd0, sb.pop_front()});
      end
   end

   // All tasks start and end just after a rising edge
   task automatic send(input logic [31:0] d, input logic s, input logic [15:0] ed, input logic eo);
      int w = 0;
      din = d; sat_mode = s; in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         w++;
         if (w > 50) begin chk("send_timeout", 32'd0, 32'd1); break; end
      end
      sb.push_back({ed, eo});
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("latency_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic stream_ovf(input int n);
      din = 32'h0001_0000; sat_mode = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (!in_ready) chk("stream_ready", 32'd0, 32'd1);
         else sb.push_back({16'h7fff, 1'b1});
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
      din = '0; sat_mode = 1'b0;
      tbl[0] = '{32'h0000_1234, 1'b0, 16'h1234, 1'b0};
      tbl[1] = '{32'hffff_8000, 1'b0, 16'h8000, 1'b0};
      tbl[2] = '{32'h0000_7fff, 1'b1, 16'h7fff, 1'b0};
      tbl[3] = '{32'h0000_8000, 1'b1, 16'h7fff, 1'b1};
      tbl[4] = '{32'h0000_8000, 1'b0, 16'h8000, 1'b1};
      tbl[5] = '{32'h8000_0000, 1'b1, 16'h8000, 1'b1};
      tbl[6] = '{32'h8000_0000, 1'b0, 16'h0000, 1'b1};
      tbl[7] = '{32'hffff_7fff, 1'b1, 16'h8000, 1'b1};
      tbl[8] = '{32'hffff_7fff, 1'b0, 16'h7fff, 1'b1};
      tbl[9] = '{32'hffff_ffff, 1'b1, 16'hffff, 1'b0};
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_dout", {16'd0, dout}, 32'd0);
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
      chk("rst_ovf_cnt", {24'd0, ovf_cnt}, 32'd0);
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
      chk("ready_low_before_release", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("ready_after_release", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) send(tbl[i].d, tbl[i].s, tbl[i].ed, tbl[i].eo);
      chk("cnt_after_table", {24'd0, ovf_cnt}, 32'd6);
      // full throughput: 10 back-to-back words
      in_valid = 1'b1; sat_mode = 1'b0;
      for (int i = 0; i < 10; i++) begin
         din = 32'(i - 5);
         @(negedge clk);
         chk("tput_in_ready", {31'd0, in_ready}, 32'd1);
         if (i > 0) chk("tput_out_valid", {31'd0, out_valid}, 32'd1);
         sb.push_back({16'(i - 5), 1'b0});
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("tput_last_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("tput_drained", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      // backpressure: three words offered with the consumer stalled
      out_ready = 1'b0; in_valid = 1'b1; sat_mode = 1'b0; din = 32'h11;
      @(negedge clk); chk("bp_rdy1", {31'd0, in_ready}, 32'd1); sb.push_back({16'h0011, 1'b0});
      @(posedge clk); #1 din = 32'h22;
      @(negedge clk); chk("bp_rdy2", {31'd0, in_ready}, 32'd1); sb.push_back({16'h0022, 1'b0});
      @(posedge clk); #1 din = 32'h33;
      @(negedge clk); chk("bp_full3", {31'd0, in_ready}, 32'd0); chk("bp_hold3", {16'd0, dout}, 32'h11);
      @(posedge clk); #1;
      @(negedge clk); chk("bp_full4", {31'd0, in_ready}, 32'd0); chk("bp_hold4", {16'd0, dout}, 32'h11);
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk); chk("bp_full5", {31'd0, in_ready}, 32'd0); chk("bp_valid5", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk); chk("bp_reready", {31'd0, in_ready}, 32'd1); chk("bp_head2", {16'd0, dout}, 32'h22);
      sb.push_back({16'h0033, 1'b0});
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk); chk("bp_head3", {16'd0, dout}, 32'h33);
      @(posedge clk); #1;
      // counter saturation and clear priority
      ovf_clr = 1'b1;
      @(posedge clk); #1 ovf_clr = 1'b0;
      stream_ovf(255);
      @(negedge clk); chk("cnt_255", {24'd0, ovf_cnt}, 32'd255);
      @(posedge clk); #1;
      stream_ovf(2);
      @(negedge clk); chk("cnt_sat", {24'd0, ovf_cnt}, 32'd255);
      @(posedge clk); #1;
      ovf_clr = 1'b1; din = 32'h8000_0000; sat_mode = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) sb.push_back({16'h8000, 1'b1}); else chk("clr_acc_ready", 32'd0, 32'd1);
      @(posedge clk); #1 ovf_clr = 1'b0; in_valid = 1'b0;
      @(negedge clk); chk("cnt_clr_and_ovf", {24'd0, ovf_cnt}, 32'd1);
      @(posedge clk); #1 ovf_clr = 1'b1;
      @(posedge clk); #1 ovf_clr = 1'b0;
      @(negedge clk); chk("cnt_clr_alone", {24'd0, ovf_cnt}, 32'd0);
      @(posedge clk); #1;
      // reset with a full buffer
      out_ready = 1'b0; in_valid = 1'b1; din = 32'h0004_0000; sat_mode = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      in_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
      chk("pre_rst_cnt", {24'd0, ovf_cnt}, 32'd2);
      @(posedge clk); #1 reset_n = 1'b0;
      @(posedge clk); #1;
      sb.delete();
      @(negedge clk);
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_dout", {16'd0, dout}, 32'd0);
      chk("mid_rst_cnt", {24'd0, ovf_cnt}, 32'd0);
      chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1 reset_n = 1'b1; out_ready = 1'b1;
      @(negedge clk); chk("mid_rel_ready_low", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_rel_ready", {31'd0, in_ready}, 32'd1);
      chk("no_stale", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk); chk("no_stale2", {31'd0, out_valid}, 32'd0);
      chk("sb_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end
endmodule
